// File: rtl/fifo_pkg.sv
// Shared defaults and error-flag encoding for the parametrised FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;

    // Sticky error flags are kept together as one small vector.
    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;
    localparam int ERR_BITS    = 2;

    typedef logic [ERR_BITS-1:0] err_t;

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO control: pointers, occupancy count, status decodes and sticky errors.
module fifo_ctrl import fifo_pkg::*; #(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = 2 ** ADDR_WIDTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("fifo_ctrl: thresholds must satisfy 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    err_t                  err_q;
    err_t                  err_evt;
    err_t                  err_d;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);

    // NOTE: every signal gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        // A pop on a full FIFO frees the slot the push lands in.
        wr_ok   = push && (!full || pop);
        rd_ok   = pop && !empty;
        err_evt = '0;
        err_evt[ERR_OVF_BIT] = push && full && !pop;
        err_evt[ERR_UDF_BIT] = pop && empty;
        if (flush) begin
            wr_ok   = 1'b0;
            rd_ok   = 1'b0;
            err_evt = '0;
        end
        // A fresh error outranks a clear in the same cycle.
        err_d = err_evt | (err_q & ~{ERR_BITS{clr_err}});
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
            err_q <= '0;
        end else begin
            err_q <= err_d;
            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
                cnt   <= '0;
            end else begin
                if (wr_ok) w_ptr <= w_ptr + 1'b1;
                if (rd_ok) r_ptr <= r_ptr + 1'b1;
                if (wr_ok && !rd_ok) begin
                    cnt <= cnt + 1'b1;
                end else if (rd_ok && !wr_ok) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign we        = wr_ok;
    assign waddr     = w_ptr;
    assign raddr     = r_ptr;
    assign count     = cnt;
    assign overflow  = err_q[ERR_OVF_BIT];
    assign underflow = err_q[ERR_UDF_BIT];

endmodule

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, asynchronous read.
module fifo_mem import fifo_pkg::*; #(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; contents are only meaningful
    // behind the pointers, and a reset would turn it into far costlier flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised first-word-fall-through synchronous FIFO: control plus storage.
module fifo_param import fifo_pkg::*; #(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = 2 ** ADDR_WIDTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;

    fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_THRESH  (AF_THRESH),
        .AE_THRESH  (AE_THRESH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .clr_err      (clr_err),
        .we           (we),
        .waddr        (waddr),
        .raddr        (raddr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: queue-based reference model plus directed literal checks.
module tb_fifo_param;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rdata;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;
    bit started = 1'b0;

    fifo_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .wdata        (wdata),
        .pop          (pop),
        .flush        (flush),
        .clr_err      (clr_err),
        .rdata        (rdata),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words plus two error bits.
    logic [DW-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit ovf_evt, udf_evt;
            ovf_evt = 1'b0;
            udf_evt = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else udf_evt = 1'b1;
                end
                if (push) begin
                    if (q.size() < DEPTH) q.push_back(wdata);
                    else ovf_evt = 1'b1;
                end
            end
            m_ovf = ovf_evt || (m_ovf && !clr_err);
            m_udf = udf_evt || (m_udf && !clr_err);
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            check("m_count", 32'(count), 32'(q.size()));
            check("m_empty", 32'(empty), 32'(q.size() == 0));
            check("m_full", 32'(full), 32'(q.size() == DEPTH));
            check("m_afull", 32'(almost_full), 32'(q.size() >= AF));
            check("m_aempty", 32'(almost_empty), 32'(q.size() <= AE));
            check("m_ovf", 32'(overflow), 32'(m_ovf));
            check("m_udf", 32'(underflow), 32'(m_udf));
            if (q.size() > 0) check("m_rdata", 32'(rdata), 32'(q[0]));
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit po, input bit fl, input bit ce);
        push = p;
        wdata = d;
        pop = po;
        flush = fl;
        clr_err = ce;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        flush = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic fill_a;
        logic [DW-1:0] v [4];
        v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) step(1'b1, v[i], 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] exp_a [4];
        exp_a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        @(posedge clk);
        #1;
        check("idle_empty", 32'(empty), 32'd1);

        // Fill with threshold crossings.
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        check("p1_count", 32'(count), 32'd1);
        check("p1_aempty", 32'(almost_empty), 32'd1);
        check("p1_rdata", 32'(rdata), 32'hA1);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        check("p2_aempty", 32'(almost_empty), 32'd0);
        check("p2_afull", 32'(almost_full), 32'd0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        check("p3_afull", 32'(almost_full), 32'd1);
        check("p3_full", 32'(full), 32'd0);
        step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
        check("p4_full", 32'(full), 32'd1);
        check("p4_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_rdata", 32'(rdata), 32'(exp_a[i]));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Overflow while full, then clear.
        fill_a();
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(rdata), 32'hA1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'd0);

        // Simultaneous push/pop while full.
        step(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
        check("fpp_count", 32'(count), 32'd4);
        check("fpp_ovf", 32'(overflow), 32'd0);
        begin
            logic [DW-1:0] exp_b [4];
            exp_b = '{8'hA2, 8'hA3, 8'hA4, 8'hB0};
            for (int i = 0; i < 4; i++) begin
                check("fpp_rdata", 32'(rdata), 32'(exp_b[i]));
                step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            end
        end

        // Simultaneous push/pop while empty.
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        check("epp_count", 32'(count), 32'd1);
        check("epp_udf", 32'(underflow), 32'd1);
        check("epp_rdata", 32'(rdata), 32'hC3);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("epp_clr", 32'(underflow), 32'd0);

        // Interleaved traffic across the pointer wrap.
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        check("wrap_h0", 32'(rdata), 32'h10);
        step(1'b1, 8'h13, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h14, 1'b0, 1'b0, 1'b0);
        check("wrap_h1", 32'(rdata), 32'h11);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h15, 1'b1, 1'b0, 1'b0);
        check("wrap_h3", 32'(rdata), 32'h13);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("wrap_h4", 32'(rdata), 32'h14);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("wrap_h5", 32'(rdata), 32'h15);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("wrap_empty", 32'(empty), 32'd1);

        // Underflow with a same-cycle clear: the new error wins.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("udf_win", 32'(underflow), 32'd1);

        // Flush with push asserted: contents dropped, errors kept.
        step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        check("fl_count", 32'(count), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_udf", 32'(underflow), 32'd1);
        step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
        check("fl_next", 32'(rdata), 32'h23);

        // Asynchronous reset in mid-cycle.
        step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_udf", 32'(underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        check("post_rst", 32'(rdata), 32'h40);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
